px_stream_proc: RTL and testbench
=================================

# px_stream_proc

Parametrised pixel-stream processor, successor to the fixed-width `top_imex` datapath. Accepts CH-channel pixels of DW bits per channel on a valid/ready stream and applies a per-beat selectable operation: pass, invert, channel reverse, or saturating gain. Results go into a DEPTH-entry first-word-fall-through FIFO with output backpressure. Sits between the file-driven testbench stimulus (or upstream pixel source) and downstream pixel consumers.

## Interface
- CH, 3, number of channels per pixel (≥1)
- DW, 8, bits per channel
- DEPTH, 4, FIFO entries (power of 2, ≥2)
- GAIN_FRAC, 4, fractional bits of i_gain (< DW)
- AW, $clog2(DEPTH), derived (localparam)

Clock and reset: one clock; reset is synchronous and active-high.

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- i_mode  in  2  operation select, sampled on each accepted beat
- i_gain  in  DW  unsigned gain, GAIN_FRAC fractional bits, sampled on each accepted beat
- i_valid  in  1  input beat valid
- i_data  in  CH*DW  input pixel; channel 0 at LSBs (CH=3: {r,g,b}, b = ch0)
- i_ready  out  1  block can accept a beat
- o_valid  out  1  FIFO head valid
- o_data  out  CH*DW  FIFO head pixel
- o_ready  in  1  downstream accepts head
- o_count  out  AW+1  current FIFO occupancy, 0..DEPTH
- o_error  out  1  sticky saturation flag

## Operation
- Push = i_valid & i_ready. Pop = o_valid & o_ready.
- i_ready = ~rst & (count < DEPTH). A pop in the same cycle does not free a slot for a push when full.
- On push, the result is computed combinationally from i_data, i_mode and i_gain. It is written into the FIFO at that edge.
- Modes, applied per channel k:
  - 0: pass, y_k = x_k.
  - 1: invert, y_k = ~x_k.
  - 2: reverse, y_k = x_(CH-1-k). With CH=1 this equals pass.
  - 3: gain, p = x_k * i_gain at full 2*DW width; y_k = p >> GAIN_FRAC (truncate). If the shifted value exceeds 2^DW-1, y_k saturates to 2^DW-1.
- o_error is set on any accepted mode-3 beat where any channel saturates. It stays set until rst. Mode change between beats is legal and does not flush or stall.
- FIFO:
  - Circular buffer with write and read pointers of AW bits, wrapping modulo DEPTH.
  - count increments on push-only, decrements on pop-only, and is unchanged on simultaneous push and pop.
  - o_valid = (count != 0).
  - o_data = mem[rd_ptr] when o_valid, else all zeros.
  - Order is strictly preserved.
- Empty FIFO with o_ready=1 and a push: the beat lands and is visible the next cycle. There is no bypass.
- Reset, including mid-stream:
  - count, pointers and o_error go to 0.
  - All queued beats are discarded.
  - i_ready=0 during the reset cycle.

## Timing
- Reset values: o_valid=0, o_data=0, o_count=0, o_error=0, i_ready=0 while rst is high. i_ready=1 in the first cycle after rst falls.
- Latency: a beat pushed at edge N is on o_data with o_valid=1 in cycle N+1 (1 cycle) if the FIFO was empty.
- Throughput: 1 beat/cycle sustained while o_ready=1.
- o_error rises in the cycle after the saturating push edge.
- o_count updates at every edge reflecting push/pop.
- The handshake follows valid/ready rules:
  - The upstream source must hold i_data stable while i_valid=1 and i_ready=0.
  - o_data and o_valid are stable while o_valid=1 and o_ready=0.

## Test plan
All scenarios use CH=3, DW=8, DEPTH=4, GAIN_FRAC=4.
- **Mode 0, stream:** mode 0, o_ready=1, push 0x102030, 0x405060, 0x708090 back-to-back → same values out, each 1 cycle after its push; o_count never exceeds 1; o_error=0.
- **Modes 1 and 2:** mode 1, push 0x00FF5A → out 0xFF00A5. Then mode 2, push 0x112233 → out 0x332211. The mode switch takes effect with no gap cycle.
- **Mode 3, gain:** mode 3, i_gain=0x18 (1.5).
  - Push 0x104080 → out 0x1860C0, o_error stays 0.
  - Push 0xC00001 → out 0xFF0001 (0xC0*1.5 saturates; 0x01*1.5 truncates to 1), o_error=1 the next cycle.
  - o_error remains 1 after later non-saturating beats.
- **Backpressure:** o_ready=0, present 5 beats A..E.
  - A..D are accepted; o_count reaches 4 and i_ready=0; E is held stable.
  - Set o_ready=1 → A,B,C,D,E emerge in order.
  - At count=2 with push and pop in the same cycle → count stays 2.
  - Pointers wrap past entry 3 without corrupting data.
- **Reset mid-operation:** with count=3 and o_error=1, assert rst for 1 cycle.
  - During the rst cycle: i_ready=0.
  - Next cycle: o_valid=0, o_data=0, o_count=0, o_error=0, i_ready=1.
  - The next pushed beat emerges first; no stale data appears.

Source files
------------

// File: rtl/px_stream_proc.sv
// px_stream_proc: per-beat pixel operation (pass / invert / channel reverse /
// saturating gain) feeding a first-word-fall-through circular FIFO with
// valid/ready handshakes on both sides and a sticky saturation flag.
module px_stream_proc #(
    parameter int CH        = 3,
    parameter int DW        = 8,
    parameter int DEPTH     = 4,
    parameter int GAIN_FRAC = 4,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        i_mode,
    input  logic [DW-1:0]     i_gain,
    input  logic              i_valid,
    input  logic [CH*DW-1:0]  i_data,
    output logic              i_ready,
    output logic              o_valid,
    output logic [CH*DW-1:0]  o_data,
    input  logic              o_ready,
    output logic [AW:0]       o_count,
    output logic              o_error
);

    localparam int CW = AW + 1;
    localparam int PW = CH * DW;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_INV  = 2'd1;
    localparam logic [1:0] MODE_REV  = 2'd2;
    localparam logic [1:0] MODE_GAIN = 2'd3;

    // Multiply one channel by the fixed-point gain, drop the fractional bits
    // and clamp to the channel maximum. Bit DW of the result flags a clamp.
    function automatic logic [DW:0] gain_sat(input logic [DW-1:0] x,
                                             input logic [DW-1:0] g);
        logic [2*DW-1:0] prod;
        logic [2*DW-1:0] shifted;
        prod    = {{DW{1'b0}}, x} * {{DW{1'b0}}, g};
        shifted = prod >> GAIN_FRAC;
        if (shifted > {{DW{1'b0}}, {DW{1'b1}}}) begin
            gain_sat = {1'b1, {DW{1'b1}}};
        end else begin
            gain_sat = {1'b0, shifted[DW-1:0]};
        end
    endfunction

    // State
    logic [PW-1:0] mem_q [DEPTH];
    logic [PW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          error_q,  error_d;

    // Combinational helpers
    logic [PW-1:0] result_s;
    logic          sat_any_s;
    logic [DW:0]   gain_s;
    logic          push_s;
    logic          pop_s;

    // Handshake: full means no push even if a pop happens this cycle.
    always_comb begin
        i_ready = ~rst & (count_q < CW'(DEPTH));
        o_valid = (count_q != {CW{1'b0}});
        push_s  = i_valid & i_ready;
        pop_s   = o_valid & o_ready;
    end

    // Per-channel operation selected by i_mode for the beat being offered.
    always_comb begin
        result_s  = {PW{1'b0}};
        sat_any_s = 1'b0;
        gain_s    = {(DW+1){1'b0}};
        for (int k = 0; k < CH; k++) begin
            case (i_mode)
                MODE_PASS: begin
                    result_s[k*DW +: DW] = i_data[k*DW +: DW];
                end
                MODE_INV: begin
                    result_s[k*DW +: DW] = ~i_data[k*DW +: DW];
                end
                MODE_REV: begin
                    result_s[k*DW +: DW] = i_data[(CH-1-k)*DW +: DW];
                end
                MODE_GAIN: begin
                    gain_s               = gain_sat(i_data[k*DW +: DW], i_gain);
                    result_s[k*DW +: DW] = gain_s[DW-1:0];
                    sat_any_s            = sat_any_s | gain_s[DW];
                end
                default: begin
                    result_s[k*DW +: DW] = i_data[k*DW +: DW];
                end
            endcase
        end
    end

    // Next-state for pointers, occupancy and the sticky saturation flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
        if (push_s && (i_mode == MODE_GAIN) && sat_any_s) begin
            error_d = 1'b1;
        end else begin
            error_d = error_q;
        end
    end

    // Storage next-state: only the slot under the write pointer changes.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push_s) begin
            mem_d[wr_ptr_q] = result_s;
        end else begin
            mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
        end
    end

    // Control registers with synchronous reset; reset discards queued beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            error_q  <= error_d;
        end
    end

    // Storage array; contents need no reset because o_data is gated by o_valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    // Output view of the FIFO head and status.
    always_comb begin
        if (o_valid) begin
            o_data = mem_q[rd_ptr_q];
        end else begin
            o_data = {PW{1'b0}};
        end
        o_count = count_q;
        o_error = error_q;
    end

endmodule

// File: tb/tb_px_stream_proc.sv
// Directed bench for px_stream_proc with hand-computed expected values.
module tb_px_stream_proc;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  i_mode;
    logic [7:0]  i_gain;
    logic        i_valid;
    logic [23:0] i_data;
    logic        i_ready;
    logic        o_valid;
    logic [23:0] o_data;
    logic        o_ready;
    logic [2:0]  o_count;
    logic        o_error;

    int checks   = 0;
    int failures = 0;

    px_stream_proc #(.CH(3), .DW(8), .DEPTH(4), .GAIN_FRAC(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_mode  (i_mode),
        .i_gain  (i_gain),
        .i_valid (i_valid),
        .i_data  (i_data),
        .i_ready (i_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_ready (o_ready),
        .o_count (o_count),
        .o_error (o_error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic v, input logic [23:0] d,
                              input logic [2:0] c);
        check_eq({tag, "_valid"}, {31'd0, o_valid}, {31'd0, v});
        check_eq({tag, "_data"},  {8'd0, o_data},   {8'd0, d});
        check_eq({tag, "_count"}, {29'd0, o_count}, {29'd0, c});
    endtask

    logic [23:0] bp_beats [6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bp_beats[0] = 24'h0000A1;
        bp_beats[1] = 24'h0000B2;
        bp_beats[2] = 24'h0000C3;
        bp_beats[3] = 24'h0000D4;
        bp_beats[4] = 24'h0000E5;
        bp_beats[5] = 24'h0000F6;

        rst = 1'b1; i_mode = 2'd0; i_gain = 8'd0; i_valid = 1'b0;
        i_data = 24'd0; o_ready = 1'b0;
        tick();
        tick();
        // Reset state
        check_eq("rst_i_ready", {31'd0, i_ready}, 32'd0);
        check_head("rst", 1'b0, 24'h000000, 3'd0);
        check_eq("rst_error", {31'd0, o_error}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_i_ready", {31'd0, i_ready}, 32'd1);

        // Mode 0 streaming, one beat per cycle, 1-cycle latency
        o_ready = 1'b1; i_mode = 2'd0; i_valid = 1'b1; i_data = 24'h102030;
        tick();
        check_head("m0_a", 1'b1, 24'h102030, 3'd1);
        i_data = 24'h405060;
        tick();
        check_head("m0_b", 1'b1, 24'h405060, 3'd1);
        i_data = 24'h708090;
        tick();
        check_head("m0_c", 1'b1, 24'h708090, 3'd1);
        i_valid = 1'b0;
        tick();
        check_head("m0_drain", 1'b0, 24'h000000, 3'd0);
        check_eq("m0_error", {31'd0, o_error}, 32'd0);

        // Modes 1 and 2 back-to-back with no gap
        i_valid = 1'b1; i_mode = 2'd1; i_data = 24'h00FF5A;
        tick();
        check_head("m1", 1'b1, 24'hFF00A5, 3'd1);
        i_mode = 2'd2; i_data = 24'h112233;
        tick();
        check_head("m2", 1'b1, 24'h332211, 3'd1);

        // Mode 3 gain 1.5
        i_mode = 2'd3; i_gain = 8'h18; i_data = 24'h104080;
        tick();
        check_head("m3_a", 1'b1, 24'h1860C0, 3'd1);
        check_eq("m3_a_error", {31'd0, o_error}, 32'd0);
        i_data = 24'hC00001;
        tick();
        check_head("m3_sat", 1'b1, 24'hFF0001, 3'd1);
        check_eq("m3_sat_error", {31'd0, o_error}, 32'd1);
        i_data = 24'h010101;
        tick();
        check_head("m3_c", 1'b1, 24'h010101, 3'd1);
        check_eq("m3_sticky", {31'd0, o_error}, 32'd1);
        i_valid = 1'b0; i_mode = 2'd0;
        tick();
        check_head("m3_drain", 1'b0, 24'h000000, 3'd0);

        // Backpressure: fill to 4, E is held
        o_ready = 1'b0; i_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_data = bp_beats[i];
            tick();
            check_eq("bp_fill_count", {29'd0, o_count}, i + 1);
        end
        check_eq("bp_full_ready", {31'd0, i_ready}, 32'd0);
        i_data = bp_beats[4];
        tick();
        check_head("bp_stall", 1'b1, bp_beats[0], 3'd4);
        // Pop while full: no push that edge
        o_ready = 1'b1;
        tick();
        check_head("bp_popA", 1'b1, bp_beats[1], 3'd3);
        // E lands (wraps to entry 0) while B pops
        tick();
        check_head("bp_pushE", 1'b1, bp_beats[2], 3'd3);
        i_valid = 1'b0;
        tick();
        check_head("bp_popC", 1'b1, bp_beats[3], 3'd2);
        // Push and pop at count 2
        i_valid = 1'b1; i_data = bp_beats[5];
        tick();
        check_head("bp_pp2", 1'b1, bp_beats[4], 3'd2);
        i_valid = 1'b0;
        tick();
        check_head("bp_popE", 1'b1, bp_beats[5], 3'd1);
        tick();
        check_head("bp_empty", 1'b0, 24'h000000, 3'd0);

        // Reset mid-operation with count=3 and o_error=1
        o_ready = 1'b0; i_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_data = 24'h010203 + 24'(i);
            tick();
        end
        check_eq("pre_rst_count", {29'd0, o_count}, 32'd3);
        check_eq("pre_rst_error", {31'd0, o_error}, 32'd1);
        rst = 1'b1; i_data = 24'h5A5A5A;
        #1;
        check_eq("mid_rst_i_ready", {31'd0, i_ready}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check_head("after_rst", 1'b0, 24'h000000, 3'd0);
        check_eq("after_rst_error", {31'd0, o_error}, 32'd0);
        check_eq("after_rst_i_ready", {31'd0, i_ready}, 32'd1);
        o_ready = 1'b1;
        tick();
        check_head("after_rst_first", 1'b1, 24'h5A5A5A, 3'd1);
        i_valid = 1'b0;
        tick();
        check_head("after_rst_drain", 1'b0, 24'h000000, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
